mmio_arbiter: RTL
=================

# mmio_arbiter

Two-requester arbiter and address decoder for the shared MMIO peripheral bus. It sits between the processor core's data-side MMIO port plus a second requester (debug/DMA port) and the CLINT and terminal UART. It grants one requester at a time using round-robin priority and sequences each access as a fixed three-cycle transaction. It decodes the address to a device strobe and returns read data or an unmapped-address error.

## Interface
Parameters:
- N_REQ, 2, number of requesters; fixed at 2.
- CLINT_BASE, 32'h0200_0000, CLINT window base; window size is CLINT_MEM_SIZE from cotm32_priv_pkg.
- UART_BASE, 32'h1000_0000, UART window base; window size is UART_MEM_SIZE.

Ports:
- i_clk  in  1  clock; all logic rises on posedge.
- i_rst  in  1  reset; synchronous, active-low.
- i_req  in  2  per-requester request; held until that requester's o_rvalid.
- i_we  in  2  per-requester write enable.
- i_addr  in  2×XLEN  per-requester byte address.
- i_wdata  in  2×XLEN  per-requester write data.
- i_lock  in  2  per-requester lock request; used only with MMIO_ARB_LOCK_EN.
- o_gnt  out  2  one-hot owner indicator.
- o_rvalid  out  2  one-cycle completion pulse to the owner.
- o_rdata  out  XLEN  registered response data, shared by both requesters.
- o_err  out  1  unmapped-address flag, valid with o_rvalid.
- o_clint_we  out  1  CLINT write strobe.
- o_clint_addr  out  $clog2(CLINT_MEM_SIZE)  CLINT offset.
- o_clint_wdata  out  XLEN  CLINT write data.
- i_clint_rdata  in  XLEN  CLINT read data.
- o_uart_re  out  1  UART read strobe.
- o_uart_we  out  1  UART write strobe.
- o_uart_addr  out  $clog2(UART_MEM_SIZE)  UART offset.
- o_uart_wdata  out  XLEN  UART write data.
- i_uart_rdata  in  XLEN  UART read data.

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - With no request, stay in IDLE.
  - With any request, pick the winner and latch its id, we, addr and wdata. Then go to ACCESS.
- Winner selection:
  - If only one requester has i_req high, it wins.
  - If both are high, the requester that was not served last wins.
  - The last-served pointer resets to 1, so requester 0 wins the first tie.
- Address decode on the latched address:
  - CLINT hit: CLINT_BASE ≤ addr < CLINT_BASE+CLINT_MEM_SIZE.
  - UART hit: UART_BASE ≤ addr < UART_BASE+UART_MEM_SIZE.
  - Anything else is a miss.
  - Device offset is addr − base, truncated to the device address width.
- ACCESS, one cycle:
  - Drive the device offset and wdata.
  - Strobe exactly one of o_clint_we, o_uart_we or o_uart_re. CLINT reads need no strobe.
  - A miss drives no strobe.
- WAIT, one cycle:
  - Offset stays driven and all strobes are low.
  - At the end of the cycle, sample device rdata into o_rdata.
  - Reads capture rdata. Writes and misses load 0.
- RESP, one cycle:
  - o_rvalid[owner]=1.
  - o_err=1 on a miss.
  - Update the last-served pointer to the owner. Go to IDLE.
- o_gnt[owner] is high in ACCESS, WAIT and RESP, and low in IDLE.
- Requests are sampled only in IDLE. A request that arrives in any other state waits.
- Device offset and wdata outputs hold their last value between transactions. Strobes are 0 outside ACCESS.

## Timing
- Request sampled at edge k: ACCESS in cycle k+1, WAIT in k+2, RESP (o_rvalid) in k+3, IDLE in k+4.
- Maximum throughput is one transaction per 4 cycles.
- Devices must present read data in the cycle after their strobe.
- Reset values: o_gnt=0, o_rvalid=0, o_rdata=0, o_err=0, all strobes 0, device offsets and wdata 0, state IDLE, last-served pointer 1, lock cleared.
- Reset asserted in any state takes effect at the next edge. An in-flight transaction is dropped with no o_rvalid.
- If a requester drops i_req mid-transaction, the transaction still completes from latched values.

## Configuration
- MMIO_ARB_LOCK_EN defined:
  - If the owner has i_lock high during its RESP cycle, the arbiter stays locked to it.
  - While locked, IDLE considers only the locked requester. The other requester waits even if it is requesting.
  - The lock clears in any RESP where the owner's i_lock is low, and on reset.
- Macro undefined: i_lock is ignored and the arbiter is pure round-robin.

## Test plan
- Req0 reads 0x0200_0004 with CLINT rdata 0xDEAD_BEEF:
  - o_gnt=01 for cycles 1–3.
  - No CLINT/UART strobe.
  - o_rvalid=01 and o_rdata=0xDEAD_BEEF in cycle 3.
- Req1 writes 0x41 to UART_BASE:
  - o_uart_we=1 for exactly the ACCESS cycle, with o_uart_addr=0 and o_uart_wdata=0x41.
  - o_rvalid=10 in RESP.
- Both requesters hold reads continuously:
  - Grants alternate 0,1,0,1 starting with requester 0.
  - o_rvalid pulses 4 cycles apart.
- Req0 accesses 0x3000_0000:
  - No strobes.
  - o_err=1, o_rdata=0 and o_rvalid=01 in cycle 3.
- i_rst low during WAIT:
  - All outputs are 0 after the next edge and no o_rvalid is issued.
  - The next tie is granted to requester 0.
- With MMIO_ARB_LOCK_EN, req0 performs 3 accesses with i_lock=1, then one with i_lock=0, while req1 requests throughout:
  - Req1 is first granted after req0's fourth RESP.
  - Without the macro, grants alternate.

Source files
------------

// File: rtl/mmio_arbiter.sv
// rtl/mmio_arbiter.sv - two-requester round-robin MMIO arbiter with CLINT/UART address decode
// Optional owner lock is compiled in with MMIO_ARB_LOCK_EN.
module mmio_arbiter #(
   parameter int              N_REQ          = 2,
   parameter int              XLEN           = 32,
   parameter logic [XLEN-1:0] CLINT_BASE     = 32'h0200_0000,
   parameter logic [XLEN-1:0] CLINT_MEM_SIZE = 32'h0001_0000,
   parameter logic [XLEN-1:0] UART_BASE      = 32'h1000_0000,
   parameter logic [XLEN-1:0] UART_MEM_SIZE  = 32'h0000_1000,
   localparam int             CW             = $clog2(CLINT_MEM_SIZE),
   localparam int             UW             = $clog2(UART_MEM_SIZE)
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [N_REQ-1:0]           i_req,
   input  logic [N_REQ-1:0]           i_we,
   input  logic [N_REQ-1:0][XLEN-1:0] i_addr,
   input  logic [N_REQ-1:0][XLEN-1:0] i_wdata,
   input  logic [N_REQ-1:0]           i_lock,
   output logic [N_REQ-1:0]           o_gnt,
   output logic [N_REQ-1:0]           o_rvalid,
   output logic [XLEN-1:0]            o_rdata,
   output logic                       o_err,
   output logic                       o_clint_we,
   output logic [CW-1:0]              o_clint_addr,
   output logic [XLEN-1:0]            o_clint_wdata,
   input  logic [XLEN-1:0]            i_clint_rdata,
   output logic                       o_uart_re,
   output logic                       o_uart_we,
   output logic [UW-1:0]              o_uart_addr,
   output logic [XLEN-1:0]            o_uart_wdata,
   input  logic [XLEN-1:0]            i_uart_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   state_t            state_q, state_d;
   logic              id_q, id_d;
   logic              we_q, we_d;
   logic              clint_hit_q, clint_hit_d;
   logic              uart_hit_q, uart_hit_d;
   logic              last_q, last_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [N_REQ-1:0]  rvalid_q, rvalid_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              clint_we_q, clint_we_d;
   logic [CW-1:0]     clint_addr_q, clint_addr_d;
   logic [XLEN-1:0]   clint_wdata_q, clint_wdata_d;
   logic              uart_re_q, uart_re_d;
   logic              uart_we_q, uart_we_d;
   logic [UW-1:0]     uart_addr_q, uart_addr_d;
   logic [XLEN-1:0]   uart_wdata_q, uart_wdata_d;

   logic [N_REQ-1:0]  req_eff;
   logic              win;
   logic [XLEN-1:0]   win_addr;
   logic              sel_clint, sel_uart;

`ifdef MMIO_ARB_LOCK_EN
   logic              lock_q, lock_d;

   // While locked only the last-served requester is visible to the arbiter.
   assign req_eff = lock_q ? (i_req & {last_q, ~last_q}) : i_req;
`else
   logic              unused_lock;

   assign unused_lock = ^i_lock;
   assign req_eff     = i_req;
`endif

   always_comb begin
      win = 1'b0;
      if (req_eff == 2'b11) begin
         win = ~last_q;
      end else begin
         win = req_eff[1];
      end
   end

   assign win_addr  = i_addr[win];
   assign sel_clint = (win_addr >= CLINT_BASE) && (win_addr < CLINT_BASE + CLINT_MEM_SIZE);
   assign sel_uart  = (win_addr >= UART_BASE) && (win_addr < UART_BASE + UART_MEM_SIZE);

   always_comb begin
      state_d       = state_q;
      id_d          = id_q;
      we_d          = we_q;
      clint_hit_d   = clint_hit_q;
      uart_hit_d    = uart_hit_q;
      last_d        = last_q;
      gnt_d         = gnt_q;
      rdata_d       = rdata_q;
      clint_addr_d  = clint_addr_q;
      clint_wdata_d = clint_wdata_q;
      uart_addr_d   = uart_addr_q;
      uart_wdata_d  = uart_wdata_q;
      rvalid_d      = '0;
      err_d         = 1'b0;
      clint_we_d    = 1'b0;
      uart_re_d     = 1'b0;
      uart_we_d     = 1'b0;
`ifdef MMIO_ARB_LOCK_EN
      lock_d        = lock_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (|req_eff) begin
               id_d        = win;
               we_d        = i_we[win];
               clint_hit_d = sel_clint;
               uart_hit_d  = sel_uart;
               gnt_d       = '0;
               gnt_d[win]  = 1'b1;
               // Strobes are registered here so they appear exactly in ACCESS.
               if (sel_clint) begin
                  clint_addr_d  = CW'(win_addr - CLINT_BASE);
                  clint_wdata_d = i_wdata[win];
                  clint_we_d    = i_we[win];
               end
               if (sel_uart) begin
                  uart_addr_d  = UW'(win_addr - UART_BASE);
                  uart_wdata_d = i_wdata[win];
                  uart_we_d    = i_we[win];
                  uart_re_d    = ~i_we[win];
               end
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            state_d = WAIT;
         end
         WAIT: begin
            rdata_d = '0;
            if (!we_q && clint_hit_q) begin
               rdata_d = i_clint_rdata;
            end else if (!we_q && uart_hit_q) begin
               rdata_d = i_uart_rdata;
            end
            rvalid_d[id_q] = 1'b1;
            err_d          = ~(clint_hit_q | uart_hit_q);
            state_d        = RESP;
         end
         RESP: begin
            last_d  = id_q;
            gnt_d   = '0;
`ifdef MMIO_ARB_LOCK_EN
            lock_d  = i_lock[id_q];
`endif
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q       <= IDLE;
         id_q          <= 1'b0;
         we_q          <= 1'b0;
         clint_hit_q   <= 1'b0;
         uart_hit_q    <= 1'b0;
         last_q        <= 1'b1;
         gnt_q         <= '0;
         rvalid_q      <= '0;
         rdata_q       <= '0;
         err_q         <= 1'b0;
         clint_we_q    <= 1'b0;
         clint_addr_q  <= '0;
         clint_wdata_q <= '0;
         uart_re_q     <= 1'b0;
         uart_we_q     <= 1'b0;
         uart_addr_q   <= '0;
         uart_wdata_q  <= '0;
`ifdef MMIO_ARB_LOCK_EN
         lock_q        <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         id_q          <= id_d;
         we_q          <= we_d;
         clint_hit_q   <= clint_hit_d;
         uart_hit_q    <= uart_hit_d;
         last_q        <= last_d;
         gnt_q         <= gnt_d;
         rvalid_q      <= rvalid_d;
         rdata_q       <= rdata_d;
         err_q         <= err_d;
         clint_we_q    <= clint_we_d;
         clint_addr_q  <= clint_addr_d;
         clint_wdata_q <= clint_wdata_d;
         uart_re_q     <= uart_re_d;
         uart_we_q     <= uart_we_d;
         uart_addr_q   <= uart_addr_d;
         uart_wdata_q  <= uart_wdata_d;
`ifdef MMIO_ARB_LOCK_EN
         lock_q        <= lock_d;
`endif
      end
   end

   assign o_gnt         = gnt_q;
   assign o_rvalid      = rvalid_q;
   assign o_rdata       = rdata_q;
   assign o_err         = err_q;
   assign o_clint_we    = clint_we_q;
   assign o_clint_addr  = clint_addr_q;
   assign o_clint_wdata = clint_wdata_q;
   assign o_uart_re     = uart_re_q;
   assign o_uart_we     = uart_we_q;
   assign o_uart_addr   = uart_addr_q;
   assign o_uart_wdata  = uart_wdata_q;

endmodule
